my_3d4d_tx: RTL and testbench
=============================

Name: my_3d4d_tx

Overview:
Transmit-side 3b/4b encoder and serializer. It feeds the 4D3D decoder stage that turns 4-bit symbols plus running disparity back into 3-bit words. It accepts 3-bit words over a valid/ready handshake and encodes each with running disparity (RD) into a 4-bit code. Each code is shifted onto a 1-bit line, with a strobe marking symbol boundaries so the downstream deserializer can frame it.

Parameters:
RD_INIT, 0, running disparity value loaded at reset (1 bit)
MSB_FIRST, 1, 1 = code bit 3 shifted first; 0 = bit 0 first

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous, active-high reset
din  input  3  data word to encode
din_valid  input  1  din holds a word
din_ready  output  1  encoder accepts din this cycle
ser_out  output  1  serial code bit
sym_start  output  1  high during the first bit of each symbol
sym_out  output  4  code currently being shifted (held for all 4 bit cycles)
rd  output  1  current running disparity; same meaning as decoder CDR
idle  output  1  no symbol in flight

Behaviour:
- Reset values, asserted on the rst edge and applied the next cycle:
  - ser_out=0, sym_start=0, sym_out=0, rd=RD_INIT, idle=1, din_ready=0 while rst=1.
  - Bit counter=0, state=IDLE.
- States:
  - IDLE: din_ready=1.
  - SHIFT: 2-bit counter runs 0..3. din_ready=1 only when counter=3, so symbols go back-to-back.
- Transfer occurs on a clk edge with din_valid & din_ready. On transfer:
  - Encode din with the pre-transfer rd.
  - Load sym_out and clear the counter.
  - Enter SHIFT; update rd.
- Latency: word accepted at edge N; its first bit appears on ser_out in cycle N+1 with sym_start=1; the last bit appears in cycle N+4.
- Code table, rd=0 (din -> code):
  - 000->1011, 001->1001, 010->0101, 011->1100
  - 100->1101, 101->1010, 110->0110, 111->0111
- Code table, rd=1 (din -> code):
  - 000->0100, 001->1001, 010->0101, 011->0011
  - 100->0010, 101->1010, 110->0110, 111->1000
- RD rule: din in {000,100,111} toggles rd at the transfer edge; all other words leave rd unchanged.
- ser_out: sym_out bit (3-counter) when MSB_FIRST=1, else bit counter.
- Counter=3 without a transfer: return to IDLE next cycle. Then ser_out=0, sym_start=0, idle=1, sym_out holds the last code.
- din is sampled only at the transfer; changes to din mid-symbol are ignored.
- rst mid-symbol: the symbol is aborted (no partial completion), rd=RD_INIT, and the next transfer starts a fresh symbol.
- Simultaneous rst and din_valid: rst wins, no transfer.

Optional Feature:
- Macro: MY_3D4D_IDLE_FILL_EN.
- Defined: when no transfer occurs at the end of a symbol, or in IDLE, transmit filler code 1010 (encoding of 101, balanced, rd unchanged) with sym_start framing every 4 cycles. idle=1 during filler. din_ready=1 only in the filler's last bit cycle or before the first filler begins. ser_out is never left static.
- Not defined: the line idles at 0 as described above.

Test Plan:
1. Reset with RD_INIT=0, then send 000 -> ser_out 1,0,1,1 in cycles N+1..N+4, sym_start high in N+1 only, rd=1 from N+1.
2. Continuing at rd=1, send 000 then 111 back-to-back -> 0100 then 0111. rd goes 1->0 after 000, then 0->1 after 111. No gap cycle between symbols.
3. rd=0, stream 001,011,110 with din_valid held -> contiguous 1001 1100 0110 (12 cycles). sym_start at cycles 1,5,9; rd stays 0; din_ready high only on cycles 4,8,12.
4. Drop din_valid after one symbol -> ser_out=0, idle=1, din_ready=1 from the next cycle. With MY_3D4D_IDLE_FILL_EN, ser_out repeats 1,0,1,0 with sym_start every 4th cycle instead.
5. Assert rst during the 2nd bit of a 100 symbol sent at rd=1 (code 0010) -> ser_out 0 and rd=RD_INIT the cycle after. A following 111 encodes 0111.
6. MSB_FIRST=0, rd=0, send 100 -> ser_out 1,0,1,1 (code 1101 LSB first), rd=1.

Source files
------------

// File: rtl/my_3d4d_tx.sv
// 3b/4b running-disparity encoder and 1-bit serializer with symbol-start framing.
// Optional idle filler (code 1010 framed every 4 cycles) enabled by `define MY_3D4D_IDLE_FILL_EN.
module my_3d4d_tx #(
   parameter logic RD_INIT   = 1'b0,
   parameter logic MSB_FIRST = 1'b1
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [2:0] din,
   input  logic       din_valid,
   output logic       din_ready,
   output logic       ser_out,
   output logic       sym_start,
   output logic [3:0] sym_out,
   output logic       rd,
   output logic       idle
);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_FILL  = 2'd2
   } state_t;

`ifdef MY_3D4D_IDLE_FILL_EN
   localparam logic [3:0] FILL_CODE = 4'b1010;
`endif

   function automatic logic [3:0] encode(input logic rd_in, input logic [2:0] d);
      logic [3:0] code;
      case ({rd_in, d})
         4'b0_000: code = 4'b1011;
         4'b0_001: code = 4'b1001;
         4'b0_010: code = 4'b0101;
         4'b0_011: code = 4'b1100;
         4'b0_100: code = 4'b1101;
         4'b0_101: code = 4'b1010;
         4'b0_110: code = 4'b0110;
         4'b0_111: code = 4'b0111;
         4'b1_000: code = 4'b0100;
         4'b1_001: code = 4'b1001;
         4'b1_010: code = 4'b0101;
         4'b1_011: code = 4'b0011;
         4'b1_100: code = 4'b0010;
         4'b1_101: code = 4'b1010;
         4'b1_110: code = 4'b0110;
         4'b1_111: code = 4'b1000;
         default:  code = 4'b0000;
      endcase
      return code;
   endfunction

   // Unbalanced codes (000, 100, 111) are the only ones that flip disparity.
   function automatic logic rd_flip(input logic [2:0] d);
      return (d == 3'b000) || (d == 3'b100) || (d == 3'b111);
   endfunction

   function automatic logic pick_bit(input logic [3:0] code, input logic [1:0] k);
      logic [1:0] msb_idx;
      msb_idx = 2'd3 - k;
      return MSB_FIRST ? code[msb_idx] : code[k];
   endfunction

   state_t     state_q;
   logic [1:0] cnt_q;
   logic [1:0] cnt_d;
   logic [3:0] sym_q;
   logic [3:0] code_d;
   logic       rd_q;
   logic       rd_d;
   logic       ser_q;
   logic       start_q;
   logic       idle_q;
   logic       xfer;

   assign din_ready = ~rst & ((state_q == S_IDLE) | (cnt_q == 2'd3));
   assign xfer      = din_valid & din_ready;
   assign code_d    = encode(rd_q, din);
   assign rd_d      = rd_q ^ rd_flip(din);
   assign cnt_d     = cnt_q + 2'd1;

   // Single FSM: accepts words, shifts codes, and returns to idle (or filler) between symbols.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         cnt_q   <= 2'd0;
         sym_q   <= 4'b0000;
         rd_q    <= RD_INIT;
         ser_q   <= 1'b0;
         start_q <= 1'b0;
         idle_q  <= 1'b1;
      end else if (xfer) begin
         state_q <= S_SHIFT;
         cnt_q   <= 2'd0;
         sym_q   <= code_d;
         rd_q    <= rd_d;
         ser_q   <= pick_bit(code_d, 2'd0);
         start_q <= 1'b1;
         idle_q  <= 1'b0;
      end else begin
         case (state_q)
            S_SHIFT, S_FILL: begin
               if (cnt_q != 2'd3) begin
                  cnt_q   <= cnt_d;
                  ser_q   <= pick_bit(sym_q, cnt_d);
                  start_q <= 1'b0;
               end else begin
`ifdef MY_3D4D_IDLE_FILL_EN
                  state_q <= S_FILL;
                  cnt_q   <= 2'd0;
                  sym_q   <= FILL_CODE;
                  ser_q   <= pick_bit(FILL_CODE, 2'd0);
                  start_q <= 1'b1;
                  idle_q  <= 1'b1;
`else
                  state_q <= S_IDLE;
                  cnt_q   <= 2'd0;
                  ser_q   <= 1'b0;
                  start_q <= 1'b0;
                  idle_q  <= 1'b1;
`endif
               end
            end
            S_IDLE: begin
`ifdef MY_3D4D_IDLE_FILL_EN
               state_q <= S_FILL;
               cnt_q   <= 2'd0;
               sym_q   <= FILL_CODE;
               ser_q   <= pick_bit(FILL_CODE, 2'd0);
               start_q <= 1'b1;
               idle_q  <= 1'b1;
`else
               cnt_q   <= 2'd0;
               ser_q   <= 1'b0;
               start_q <= 1'b0;
               idle_q  <= 1'b1;
`endif
            end
            default: begin
               state_q <= S_IDLE;
               cnt_q   <= 2'd0;
               ser_q   <= 1'b0;
               start_q <= 1'b0;
               idle_q  <= 1'b1;
            end
         endcase
      end
   end

   assign ser_out   = ser_q;
   assign sym_start = start_q;
   assign sym_out   = sym_q;
   assign rd        = rd_q;
   assign idle      = idle_q;

endmodule

// File: tb/tb_my_3d4d_tx.sv
// Scoreboard bench for my_3d4d_tx: two instances (MSB-first/RD 0 and LSB-first/RD 1)
// share stimulus; a per-cycle expected-output queue is filled by a table model and popped by a monitor.
module tb_my_3d4d_tx;

   logic       clk = 1'b0;
   logic       rst;
   logic [2:0] din;
   logic       din_valid;

   logic       ready0, ser0, start0, rd0, idle0;
   logic [3:0] sym0;
   logic       ready1, ser1, start1, rd1, idle1;
   logic [3:0] sym1;

   int checks = 0;
   int fails  = 0;
   int acc_cnt = 0;
   bit armed = 1'b0;

   typedef struct {
      logic       ser0;
      logic       ser1;
      logic       start;
      logic       idle;
      logic [3:0] sym0;
      logic [3:0] sym1;
      logic       rd0;
      logic       rd1;
   } exp_t;

   exp_t q[$];

   logic [3:0] tab_rd0 [8] = '{4'b1011, 4'b1001, 4'b0101, 4'b1100,
                               4'b1101, 4'b1010, 4'b0110, 4'b0111};
   logic [3:0] tab_rd1 [8] = '{4'b0100, 4'b1001, 4'b0101, 4'b0011,
                               4'b0010, 4'b1010, 4'b0110, 4'b1000};

   always #5 clk = ~clk;

   my_3d4d_tx #(.RD_INIT(1'b0), .MSB_FIRST(1'b1)) dut0 (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(ready0),
      .ser_out(ser0), .sym_start(start0), .sym_out(sym0), .rd(rd0), .idle(idle0)
   );

   my_3d4d_tx #(.RD_INIT(1'b1), .MSB_FIRST(1'b0)) dut1 (
      .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(ready1),
      .ser_out(ser1), .sym_start(start1), .sym_out(sym1), .rd(rd1), .idle(idle1)
   );

   // Reference model: each clock edge appends the outputs expected in the following cycle(s).
   initial begin
      logic       m_rd0, m_rd1;
      logic [3:0] last0, last1, c0, c1;
      exp_t       e;
      m_rd0 = 1'b0; m_rd1 = 1'b1; last0 = 4'd0; last1 = 4'd0;
      forever begin
         @(posedge clk);
         if (rst) begin
            q.delete();
            m_rd0 = 1'b0; m_rd1 = 1'b1; last0 = 4'd0; last1 = 4'd0;
            e = '{ser0:1'b0, ser1:1'b0, start:1'b0, idle:1'b1,
                  sym0:4'd0, sym1:4'd0, rd0:m_rd0, rd1:m_rd1};
            q.push_back(e);
            armed = 1'b1;
         end else if (armed && din_valid && q.size() == 0) begin
            c0 = tab_rd0[din]; c1 = tab_rd1[din];
            if (m_rd0) c0 = tab_rd1[din];
            if (!m_rd1) c1 = tab_rd0[din];
            if (din == 3'd0 || din == 3'd4 || din == 3'd7) begin
               m_rd0 = ~m_rd0; m_rd1 = ~m_rd1;
            end
            last0 = c0; last1 = c1;
            for (int k = 0; k < 4; k++) begin
               e = '{ser0:c0[3-k], ser1:c1[k], start:(k == 0), idle:1'b0,
                     sym0:c0, sym1:c1, rd0:m_rd0, rd1:m_rd1};
               q.push_back(e);
            end
            acc_cnt++;
         end else if (armed && q.size() == 0) begin
            e = '{ser0:1'b0, ser1:1'b0, start:1'b0, idle:1'b1,
                  sym0:last0, sym1:last1, rd0:m_rd0, rd1:m_rd1};
            q.push_back(e);
         end
      end
   end

   // Monitor: compare each cycle's outputs with the front of the queue, then the handshake.
   initial begin
      exp_t       e;
      logic [7:0] act, req;
      forever begin
         @(negedge clk);
         if (armed) begin
            if (q.size() == 0) begin
               checks++; fails++;
               $display("FAIL underflow: actual queue size 0, required at least 1");
            end else begin
               e = q.pop_front();
               act = {ser0, start0, idle0, sym0, rd0};
               req = {e.ser0, e.start, e.idle, e.sym0, e.rd0};
               checks++;
               if (act !== req) begin
                  fails++;
                  $display("FAIL out0 t=%0t: actual {ser,start,idle,sym,rd}=%b required %b", $time, act, req);
               end
               act = {ser1, start1, idle1, sym1, rd1};
               req = {e.ser1, e.start, e.idle, e.sym1, e.rd1};
               checks++;
               if (act !== req) begin
                  fails++;
                  $display("FAIL out1 t=%0t: actual {ser,start,idle,sym,rd}=%b required %b", $time, act, req);
               end
            end
            #2;
            checks++;
            if ({ready0, ready1} !== {2{~rst && q.size() == 0}}) begin
               fails++;
               $display("FAIL din_ready t=%0t: actual %b%b required %b", $time, ready0, ready1,
                        ~rst && q.size() == 0);
            end
         end
      end
   end

   task automatic send(input logic [2:0] d);
      int start_cnt;
      start_cnt = acc_cnt;
      din = d;
      din_valid = 1'b1;
      for (int i = 0; i < 12 && acc_cnt == start_cnt; i++) @(negedge clk);
      checks++;
      if (acc_cnt == start_cnt) begin
         fails++;
         $display("FAIL accept_timeout: actual no transfer in 12 cycles, required transfer of %b", d);
      end
   endtask

   // Stimulus: directed scenarios, then randomized traffic with occasional resets.
   initial begin
      rst = 1'b1; din = 3'd0; din_valid = 1'b0;
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      send(3'd0);
      send(3'd0);
      send(3'd7);
      din_valid = 1'b0;
      repeat (2) @(negedge clk);
      send(3'd4);
      send(3'd1);
      send(3'd3);
      send(3'd6);
      din_valid = 1'b0;
      repeat (6) @(negedge clk);
      send(3'd7);
      send(3'd4);
      din_valid = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      send(3'd7);
      din_valid = 1'b0;
      repeat (5) @(negedge clk);
      for (int i = 0; i < 800; i++) begin
         din       = 3'($urandom_range(0, 7));
         din_valid = ($urandom_range(0, 9) < 7);
         rst       = ($urandom_range(0, 63) == 0);
         @(negedge clk);
      end
      rst = 1'b0; din_valid = 1'b0;
      repeat (8) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
